// File: rtl/lac_seq_ctrl.sv
// Sequencer that runs one wide add/subtract through an external SLICE_W-bit
// look-ahead-carry unit, one slice per cycle, and registers the full result.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. in_ready is 1 in IDLE, 0 in RUN, and follows out_ready in
// DONE. out_valid is 1 only in DONE, and the result outputs are held there
// until out_ready is 1.
module lac_seq_ctrl #(
  parameter int SLICE_W = 16,
  parameter int NSLICE  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] a_in,
  input  logic [SLICE_W*NSLICE-1:0] b_in,
  input  logic                      cin_in,
  input  logic                      sub_in,
  output logic [SLICE_W-1:0]        lac_a,
  output logic [SLICE_W-1:0]        lac_b,
  output logic                      lac_cin,
  input  logic [SLICE_W-1:0]        lac_s,
  input  logic                      lac_cout,
  output logic [SLICE_W*NSLICE-1:0] sum_out,
  output logic                      cout_out,
  output logic                      ovf_out,
  output logic                      zero_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                dbg_state_o
);

  localparam int W     = SLICE_W * NSLICE;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [W-1:0]     sum_d;
  logic             accept;
  logic             run;

  assign run      = (state_q == S_RUN);
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Partial sums live in acc_q so sum_out only ever shows a complete result.
  always_comb begin
    sum_d = acc_q;
    sum_d[idx_q*SLICE_W +: SLICE_W] = lac_s;
  end

  assign lac_a   = run ? a_q[idx_q*SLICE_W +: SLICE_W] : '0;
  assign lac_b   = run ? b_q[idx_q*SLICE_W +: SLICE_W] : '0;
  assign lac_cin = run & carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a_in;
      b_q     <= sub_in ? ~b_in : b_in;
      carry_q <= sub_in | cin_in;
      acc_q   <= '0;
      idx_q   <= '0;
      state_q <= S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_q   <= sum_d;
          carry_q <= lac_cout;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_DONE;
            sum_q   <= sum_d;
            cout_q  <= lac_cout;
            ovf_q   <= (a_q[W-1] == b_q[W-1]) & (sum_d[W-1] != a_q[W-1]);
            zero_q  <= ~|sum_d;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        S_IDLE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sum_out     = sum_q;
  assign cout_out    = cout_q;
  assign ovf_out     = ovf_q;
  assign zero_out    = zero_q;
  assign out_valid   = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lac_seq_ctrl.sv
// Bench for lac_seq_ctrl: behavioural lac_unit, directed and random operations,
// result scoreboard, back-pressure and mid-operation reset.
module tb_lac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        cin_in;
  logic        sub_in;
  logic [15:0] lac_a;
  logic [15:0] lac_b;
  logic        lac_cin;
  logic [15:0] lac_s;
  logic        lac_cout;
  logic [63:0] sum_out;
  logic        cout_out;
  logic        ovf_out;
  logic        zero_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [66:0] exp_q[$];

  lac_seq_ctrl #(.SLICE_W(16), .NSLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in), .sub_in(sub_in),
    .lac_a(lac_a), .lac_b(lac_b), .lac_cin(lac_cin),
    .lac_s(lac_s), .lac_cout(lac_cout),
    .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out),
    .zero_out(zero_out), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state_o(dbg_state)
  );

  // Behavioural external lac_unit.
  assign {lac_cout, lac_s} = {1'b0, lac_a} + {1'b0, lac_b} + 17'(lac_cin);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: packs {cout, ovf, zero, sum}.
  function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] bb;
    logic [64:0] r;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
    return {r[64], (a[63] == bb[63]) && (r[63] != a[63]), r[63:0] == 64'd0, r[63:0]};
  endfunction

  // Scoreboard: every completed result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [66:0] e;
      check("sb_qsize", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_sum",  sum_out,  e[63:0]);
        check("sb_zero", 64'(zero_out), 64'(e[64]));
        check("sb_ovf",  64'(ovf_out),  64'(e[65]));
        check("sb_cout", 64'(cout_out), 64'(e[66]));
      end
    end
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, input logic [66:0] exp);
    logic [63:0] bb;
    int edges;
    bb = sub ? ~b : b;
    a_in = a; b_in = b; cin_in = cin; sub_in = sub; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    check("in_ready_wait", 64'(in_ready), 64'd1);
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
    cin_in = 1'($urandom_range(0, 1)); sub_in = 1'($urandom_range(0, 1));
    check("run_in_ready", 64'(in_ready), 64'd0);
    check("slice0_a",   64'(lac_a),   64'(a[15:0]));
    check("slice0_b",   64'(lac_b),   64'(bb[15:0]));
    check("slice0_cin", 64'(lac_cin), 64'(sub ? 1'b1 : cin));
    edges = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check("latency", 64'(edges), 64'd4);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc, rs;
    logic [66:0] e1, e2;
    int          edges;

    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    cin_in = 1'b0; sub_in = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       sum_out,        64'd0);
    check("rst_flags",     64'({cout_out, ovf_out, zero_out}), 64'd0);
    check("rst_lac",       64'({lac_cin, lac_a, lac_b}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Directed cases with hand-computed results {cout, ovf, zero, sum}.
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, {3'b000, 64'h0000_0000_0001_0000});
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {3'b101, 64'h0});
    run_op(64'd5, 64'd7, 1'b0, 1'b1, {3'b000, 64'hFFFF_FFFF_FFFF_FFFE});
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {3'b010, 64'h8000_0000_0000_0000});
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, {3'b101, 64'h0});
    run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b1, 1'b0, {3'b000, 64'h0001_0000_0000_0000});

    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if (i % 4 == 1) rb = ~ra;
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    tick();

    // Back-pressure in DONE with a pending request, then same-edge accept.
    out_ready = 1'b0;
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    e1 = model(ra, rb, 1'b1, 1'b0);
    run_op(ra, rb, 1'b1, 1'b0, e1);
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    e2 = model(ra, rb, 1'b0, 1'b1);
    a_in = ra; b_in = rb; cin_in = 1'b0; sub_in = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_valid",    64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready),  64'd0);
      check("hold_sum",      sum_out,        e1[63:0]);
      check("hold_flags",    64'({cout_out, ovf_out, zero_out}), 64'(e1[66:64]));
    end
    exp_q.push_back(e2);
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_run_valid", 64'(out_valid), 64'd0);
    edges = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check("b2b_latency", 64'(edges), 64'd4);
    repeat (2) tick();

    // Reset in the middle of RUN at slice index 2.
    a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'd3; cin_in = 1'b0; sub_in = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_lac_a", 64'(lac_a), 64'hFFFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready),  64'd1);
    check("mid_rst_lac",      64'({lac_cin, lac_a, lac_b}), 64'd0);
    check("mid_rst_sum",      sum_out, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b1,
           {3'b000, 64'hF012_3456_789A_BCDE});
    repeat (3) tick();
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
